// File: rtl/vga_scan_engine_if.sv
// Framebuffer read bus and VGA DAC pins of the raster engine, grouped as one bundle.
// There is no handshake: the engine issues one read per pixel strobe and never stalls.
interface vga_scan_engine_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] FB_ADDR;
    logic [8:0]        FB_RDATA;
    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              VGA_BLANK_N;
    logic              PIX_EN;
    logic              FRAME_START;

    modport master (
        output FB_ADDR, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, PIX_EN, FRAME_START,
        input  FB_RDATA
    );

    modport slave (
        input  FB_ADDR, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, PIX_EN, FRAME_START,
        output FB_RDATA
    );
endinterface

// File: rtl/vga_scan_engine.sv
// VGA raster engine: programmable sync timing, pixel-replicated 9-bit framebuffer scan,
// and a sync/blank delay line matched to the framebuffer read latency.
module vga_scan_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int CLK_DIV     = 2,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LAT      = 1,
    parameter int ADDR_W      = 15
) (
    input  logic              CLK,
    input  logic              RST,
    vga_scan_engine_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              pix_q, pix_d;
    logic              fs_q, fs_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [2:0]        dec0;
    logic [2:0]        tap;
    logic              nxt_active;

    function automatic logic [7:0] expand(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    // Stage-0 decode of the current raster position: {active, hs_act, vs_act}.
    assign dec0 = {(int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE),
                   (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC),
                   (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC)};

    generate
        if (RD_LAT == 0) begin : g_no_delay
            assign tap = dec0;
        end else begin : g_delay
            logic [2:0] sh_q [RD_LAT];
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < RD_LAT; i++) sh_q[i] <= 3'b000;
                end else if (pix_q) begin
                    sh_q[0] <= dec0;
                    for (int i = 1; i < RD_LAT; i++) sh_q[i] <= sh_q[i-1];
                end
            end
            assign tap = sh_q[RD_LAT-1];
        end
    endgenerate

    always_comb begin
        div_d     = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
        h_d       = h_q;
        v_d       = v_q;
        fb_addr_d = fb_addr_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;

        if (pix_q) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end

        // Strobe and frame pulse are registered from next state so they line up with the counters.
        pix_d      = (div_d == DW'(CLK_DIV - 1));
        fs_d       = pix_d && (h_d == HW'(H_TOTAL - 1)) && (v_d == VW'(V_TOTAL - 1));
        nxt_active = (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);

        // Modular arithmetic: the low ADDR_W bits equal the truncated full-width product.
        if (pix_q && nxt_active) begin
            fb_addr_d = ADDR_W'(int'(v_d) >> SCALE_SHIFT) * ADDR_W'(FB_W)
                      + ADDR_W'(int'(h_d) >> SCALE_SHIFT);
        end

        if (pix_q) begin
            blank_n_d = tap[2];
            hs_d      = tap[1] ? HS_POL : ~HS_POL;
            vs_d      = tap[0] ? VS_POL : ~VS_POL;
            r_d       = tap[2] ? expand(vga.FB_RDATA[8:6]) : 8'd0;
            g_d       = tap[2] ? expand(vga.FB_RDATA[5:3]) : 8'd0;
            b_d       = tap[2] ? expand(vga.FB_RDATA[2:0]) : 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            pix_q     <= 1'b0;
            fs_q      <= 1'b0;
            fb_addr_q <= '0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            pix_q     <= pix_d;
            fs_q      <= fs_d;
            fb_addr_q <= fb_addr_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign vga.FB_ADDR     = fb_addr_q;
    assign vga.VGA_R       = r_q;
    assign vga.VGA_G       = g_q;
    assign vga.VGA_B       = b_q;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.PIX_EN      = pix_q;
    assign vga.FRAME_START = fs_q;
endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: two small raster configurations against a pixel-index reference model.
module tb_vga_scan_engine;
    // Config A: divided clock, replicated pixels, one-period synchronous framebuffer.
    localparam int A_DIV = 2, A_HA = 16, A_HF = 2, A_HS = 3, A_HB = 3;
    localparam int A_VA = 8, A_VF = 1, A_VS = 2, A_VB = 2;
    localparam int A_SS = 1, A_RDL = 1, A_AW = 5;
    localparam bit A_HPOL = 1'b0, A_VPOL = 1'b0;
    // Config B: undivided clock, no scaling, asynchronous framebuffer, truncated address.
    localparam int B_DIV = 1, B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_SS = 0, B_RDL = 0, B_AW = 4;
    localparam bit B_HPOL = 1'b1, B_VPOL = 1'b0;

    typedef struct packed {
        logic [4:0]  ctl;
        logic [23:0] rgb;
        logic [15:0] addr;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_cnt = 0;
    bit   armed = 0;
    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    logic [8:0] mem_a [0:(1<<A_AW)-1];
    logic [8:0] mem_b [0:(1<<B_AW)-1];
    logic [8:0] rd_a_q;
    logic [7:0] lvl [0:7] = '{8'd0, 8'd36, 8'd73, 8'd109, 8'd146, 8'd182, 8'd219, 8'd255};

    vga_scan_engine_if #(.ADDR_W(A_AW)) if_a ();
    vga_scan_engine_if #(.ADDR_W(B_AW)) if_b ();

    vga_scan_engine #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(A_HPOL), .VS_POL(A_VPOL), .CLK_DIV(A_DIV),
        .SCALE_SHIFT(A_SS), .RD_LAT(A_RDL), .ADDR_W(A_AW)
    ) dut_a (.CLK(clk), .RST(rst), .vga(if_a));

    vga_scan_engine #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL(B_HPOL), .VS_POL(B_VPOL), .CLK_DIV(B_DIV),
        .SCALE_SHIFT(B_SS), .RD_LAT(B_RDL), .ADDR_W(B_AW)
    ) dut_b (.CLK(clk), .RST(rst), .vga(if_b));

    // Framebuffer A answers one pixel period after the address; B answers combinationally.
    always @(posedge clk) if (if_a.PIX_EN) rd_a_q <= mem_a[if_a.FB_ADDR];
    assign if_a.FB_RDATA = rd_a_q;
    assign if_b.FB_RDATA = mem_b[if_b.FB_ADDR];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d time=%0t: got %0h expected %0h", tag, t_cnt, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Outputs as a function of cycles since reset: pixel index n, delayed pixel m = n-1-RD_LAT.
    function automatic exp_t predict(input int t, input bit sel);
        int d, ha, hf, hsw, hb, va, vf, vsw, vb, ss, rdl, aw, ht, vt;
        int n, h, v, ah, av, m, hm, vm, idx;
        bit hpol, vpol, strobe, fs, act, hsa, vsa;
        logic [8:0] data;
        exp_t e;
        if (!sel) begin
            d = A_DIV; ha = A_HA; hf = A_HF; hsw = A_HS; hb = A_HB;
            va = A_VA; vf = A_VF; vsw = A_VS; vb = A_VB;
            ss = A_SS; rdl = A_RDL; aw = A_AW; hpol = A_HPOL; vpol = A_VPOL;
        end else begin
            d = B_DIV; ha = B_HA; hf = B_HF; hsw = B_HS; hb = B_HB;
            va = B_VA; vf = B_VF; vsw = B_VS; vb = B_VB;
            ss = B_SS; rdl = B_RDL; aw = B_AW; hpol = B_HPOL; vpol = B_VPOL;
        end
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        // The cycle right after reset is never a strobe; afterwards one strobe per d cycles.
        if (d > 1) begin
            n = t / d;
            strobe = ((t + 1) % d) == 0;
        end else begin
            n = (t > 0) ? t - 1 : 0;
            strobe = (t >= 1);
        end
        h = n % ht;
        v = (n / ht) % vt;
        fs = strobe && (h == ht - 1) && (v == vt - 1);
        // Address of the last active pixel visited (raster always starts on an active pixel).
        if (h < ha && v < va) begin ah = h; av = v; end
        else if (v < va) begin ah = ha - 1; av = v; end
        else begin ah = ha - 1; av = va - 1; end
        e.addr = 16'(((av >> ss) * (ha >> ss) + (ah >> ss)) % (1 << aw));
        m = n - 1 - rdl;
        if (m < 0) begin
            e.ctl = {strobe, fs, ~hpol, ~vpol, 1'b0};
            e.rgb = 24'd0;
        end else begin
            hm = m % ht;
            vm = (m / ht) % vt;
            act = (hm < ha) && (vm < va);
            hsa = (hm >= ha + hf) && (hm < ha + hf + hsw);
            vsa = (vm >= va + vf) && (vm < va + vf + vsw);
            e.ctl = {strobe, fs, hsa ? hpol : ~hpol, vsa ? vpol : ~vpol, act};
            e.rgb = 24'd0;
            if (act) begin
                idx = ((vm >> ss) * (ha >> ss) + (hm >> ss)) % (1 << aw);
                data = sel ? mem_b[idx] : mem_a[idx];
                e.rgb = {lvl[data[8:6]], lvl[data[5:3]], lvl[data[2:0]]};
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t_cnt = 0;
            armed = 1;
        end else begin
            t_cnt = t_cnt + 1;
        end
        if (armed) begin
            exp_a_q.push_back(predict(t_cnt, 1'b0));
            exp_b_q.push_back(predict(t_cnt, 1'b1));
        end
    end

    // ---------------- scoreboard ----------------
    int run_a = 0, run_b = 0, last_fs_a = -1, last_fs_b = -1;
    always @(negedge clk) begin
        exp_t e;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            chk("A_ctl", 64'({if_a.PIX_EN, if_a.FRAME_START, if_a.VGA_HS, if_a.VGA_VS, if_a.VGA_BLANK_N}), 64'(e.ctl));
            chk("A_rgb", 64'({if_a.VGA_R, if_a.VGA_G, if_a.VGA_B}), 64'(e.rgb));
            chk("A_addr", 64'(if_a.FB_ADDR), 64'(e.addr));
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            chk("B_ctl", 64'({if_b.PIX_EN, if_b.FRAME_START, if_b.VGA_HS, if_b.VGA_VS, if_b.VGA_BLANK_N}), 64'(e.ctl));
            chk("B_rgb", 64'({if_b.VGA_R, if_b.VGA_G, if_b.VGA_B}), 64'(e.rgb));
            chk("B_addr", 64'(if_b.FB_ADDR), 64'(e.addr));
        end
        if (armed) begin
            if (t_cnt == 0) begin
                run_a = 0; run_b = 0; last_fs_a = -1; last_fs_b = -1;
            end else begin
                if (if_a.VGA_HS == A_HPOL) run_a++;
                else if (run_a > 0) begin
                    chk("A_hs_width", 64'(run_a), 64'(A_HS * A_DIV));
                    run_a = 0;
                end
                if (if_b.VGA_HS == B_HPOL) run_b++;
                else if (run_b > 0) begin
                    chk("B_hs_width", 64'(run_b), 64'(B_HS * B_DIV));
                    run_b = 0;
                end
                if (if_a.FRAME_START) begin
                    if (last_fs_a >= 0) chk("A_fs_period", 64'(t_cnt - last_fs_a), 64'(624));
                    last_fs_a = t_cnt;
                end
                if (if_b.FRAME_START) begin
                    if (last_fs_b >= 0) chk("B_fs_period", 64'(t_cnt - last_fs_b), 64'(98));
                    last_fs_b = t_cnt;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_mems();
        for (int i = 0; i < (1 << A_AW); i++) mem_a[i] = 9'($urandom);
        for (int i = 0; i < (1 << B_AW); i++) mem_b[i] = 9'($urandom);
        mem_a[$urandom_range(0, (1 << A_AW) - 1)] = 9'h1FF;
        mem_a[$urandom_range(0, (1 << A_AW) - 1)] = 9'b100_000_011;
        mem_b[0] = 9'b100_000_011;
        mem_b[1] = 9'h1FF;
    endtask

    task automatic pulse_reset(input int cyc);
        @(negedge clk);
        rst = 1'b1;
        load_mems();
        repeat (cyc) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_cycles(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        rst = 1'b1;
        load_mems();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_cycles(2000);

        // Directed colour expansion on the first two pixels of B after a one-cycle reset.
        pulse_reset(1);
        run_cycles(2);
        chk("B_rgb_146_0_109", 64'({if_b.VGA_R, if_b.VGA_G, if_b.VGA_B}), 64'({8'd146, 8'd0, 8'd109}));
        run_cycles(1);
        chk("B_rgb_white", 64'({if_b.VGA_R, if_b.VGA_G, if_b.VGA_B}), 64'(24'hFFFFFF));
        run_cycles(1500);

        for (int s = 0; s < 6; s++) begin
            pulse_reset($urandom_range(1, 3));
            run_cycles($urandom_range(150, 1400));
        end

        w = 0;
        while (!if_b.FRAME_START && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("B_fs_timeout", 64'(w < 200), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
